// File: rtl/stream_window_loader.sv
// ============================================================================
// stream_window_loader : NxN sliding-window extractor over a raster pixel stream
// rev 1.0
// ============================================================================
`default_nettype none

module stream_window_loader #(
   parameter  int IMAGE_WIDTH  = 5,
   parameter  int IMAGE_HEIGHT = 5,
   parameter  int N            = 3,
   parameter  int CHANNELS     = 1,
   parameter  int DATA_W       = 8,
   parameter  int STRIDE       = 1,
   localparam int PIX_W        = CHANNELS * DATA_W,
   localparam int WIN_W        = N * N * PIX_W,
   localparam int ROW_W        = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
   localparam int COL_W        = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIN_W-1:0] m_window,
   output logic [ROW_W-1:0] m_row,
   output logic [COL_W-1:0] m_col,
   output logic             frame_done
);

   localparam int NL     = N - 1;
   localparam int SLOT_W = (NL > 1) ? $clog2(NL) : 1;
   localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(N - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(N - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NL - 1);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(STRIDE - 1);

   typedef logic [PIX_W-1:0] pix_t;

   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [PH_W-1:0]   row_ph_q, row_ph_d;
   logic [PH_W-1:0]   col_ph_q, col_ph_d;
   logic              frame_done_q, frame_done_d;
   logic              m_valid_q, m_valid_d;
   logic [WIN_W-1:0]  m_window_q, m_window_d;
   logic [ROW_W-1:0]  m_row_q, m_row_d;
   logic [COL_W-1:0]  m_col_q, m_col_d;
   logic [WIN_W-1:0]  win_q, win_d;

   pix_t              lb_mem [NL][IMAGE_WIDTH];
   pix_t              col_pix [N];
   logic [SLOT_W:0]   rd_slot [NL];
   logic              accept;
   logic              win_hit;

   assign s_ready = !m_valid_q || m_ready;
   assign accept  = s_valid && s_ready;

   // Current row r lives in slot r mod (N-1); the older rows sit in the slots behind it.
   always_comb begin
      for (int k = 0; k < NL; k++) begin
         rd_slot[k] = {1'b0, slot_q} + (SLOT_W+1)'(NL - 1 - k);
         if (rd_slot[k] >= (SLOT_W+1)'(NL)) begin
            rd_slot[k] = rd_slot[k] - (SLOT_W+1)'(NL);
         end
         col_pix[NL-1-k] = lb_mem[rd_slot[k][SLOT_W-1:0]][col_q];
      end
      col_pix[N-1] = s_data;
   end

   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N - 1; j++) begin
               win_d[(i*N+j)*PIX_W +: PIX_W] = win_q[(i*N+j+1)*PIX_W +: PIX_W];
            end
            win_d[(i*N+N-1)*PIX_W +: PIX_W] = col_pix[i];
         end
      end
   end

   // Stale rows from a previous frame are never emitted: the row gate needs N-1 fresh rows first.
   assign win_hit = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST) &&
                    (row_ph_q == '0) && (col_ph_q == '0);

   always_comb begin
      row_d        = row_q;
      col_d        = col_q;
      slot_d       = slot_q;
      row_ph_d     = row_ph_q;
      col_ph_d     = col_ph_q;
      frame_done_d = 1'b0;
      m_valid_d    = m_valid_q;
      m_window_d   = m_window_q;
      m_row_d      = m_row_q;
      m_col_d      = m_col_q;

      if (accept) begin
         if (col_q == COL_LAST) begin
            col_d    = '0;
            col_ph_d = '0;
            if (row_q == ROW_LAST) begin
               row_d        = '0;
               row_ph_d     = '0;
               slot_d       = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d  = row_q + 1'b1;
               slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
               if (row_q >= ROW_FIRST) begin
                  row_ph_d = (row_ph_q == PH_LAST) ? '0 : row_ph_q + 1'b1;
               end else begin
                  row_ph_d = '0;
               end
            end
         end else begin
            col_d = col_q + 1'b1;
            if (col_q >= COL_FIRST) begin
               col_ph_d = (col_ph_q == PH_LAST) ? '0 : col_ph_q + 1'b1;
            end else begin
               col_ph_d = '0;
            end
         end
      end

      if (win_hit) begin
         m_valid_d  = 1'b1;
         m_window_d = win_d;
         m_row_d    = row_q - ROW_FIRST;
         m_col_d    = col_q - COL_FIRST;
      end else if (m_ready) begin
         m_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q        <= '0;
         col_q        <= '0;
         slot_q       <= '0;
         row_ph_q     <= '0;
         col_ph_q     <= '0;
         frame_done_q <= 1'b0;
         m_valid_q    <= 1'b0;
         m_window_q   <= '0;
         m_row_q      <= '0;
         m_col_q      <= '0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         slot_q       <= slot_d;
         row_ph_q     <= row_ph_d;
         col_ph_q     <= col_ph_d;
         frame_done_q <= frame_done_d;
         m_valid_q    <= m_valid_d;
         m_window_q   <= m_window_d;
         m_row_q      <= m_row_d;
         m_col_q      <= m_col_d;
      end
   end

   always_ff @(posedge clk) begin
      win_q <= win_d;
      if (accept) begin
         lb_mem[slot_q][col_q] <= s_data;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_window   = m_window_q;
   assign m_row      = m_row_q;
   assign m_col      = m_col_q;
   assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_window_loader.sv
// ============================================================================
// tb_stream_window_loader : scoreboard bench for the sliding-window loader
// rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stream_window_loader;

   localparam int W     = 5;
   localparam int H     = 5;
   localparam int N     = 3;
   localparam int WIN_W = N * N * 8;

   typedef struct packed {
      logic [WIN_W-1:0] win;
      logic [2:0]       row;
      logic [2:0]       col;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, s_valid, s_ready, m_valid, m_ready, frame_done;
   logic [7:0]       s_data;
   logic [WIN_W-1:0] m_window;
   logic [2:0]       m_row, m_col;

   logic             s2_valid, s2_ready, m2_valid, m2_ready, m2_fd;
   logic [7:0]       s2_data;
   logic [WIN_W-1:0] m2_window;
   logic [2:0]       m2_row, m2_col;

   stream_window_loader #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .N(N), .CHANNELS(1), .DATA_W(8), .STRIDE(1)
   ) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window), .m_row(m_row),
      .m_col(m_col), .frame_done(frame_done)
   );

   stream_window_loader #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .N(N), .CHANNELS(1), .DATA_W(8), .STRIDE(2)
   ) u_s2 (
      .clk(clk), .rst(rst), .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
      .m_valid(m2_valid), .m_ready(m2_ready), .m_window(m2_window), .m_row(m2_row),
      .m_col(m2_col), .frame_done(m2_fd)
   );

   int   errors = 0;
   int   checks = 0;
   int   win_cnt = 0;
   int   win2_cnt = 0;
   int   fd_cnt = 0;
   exp_t exp_q[$];
   exp_t got_q[$];
   exp_t exp2_q[$];
   exp_t got2_q[$];

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [WIN_W-1:0] win9(input int e0, input int e1, input int e2,
                                             input int e3, input int e4, input int e5,
                                             input int e6, input int e7, input int e8);
      return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
   endfunction

   // Pixel (r,c) of a frame is base + r*W + c + 1.
   function automatic logic [WIN_W-1:0] model_win(input int base, input int r, input int c);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            w[(i*N+j)*8 +: 8] = 8'(base + (r-N+1+i)*W + (c-N+1+j) + 1);
         end
      end
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_done) fd_cnt++;
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window: row=%0d col=%0d win=%h", m_row, m_col, m_window);
            end else begin
               chk("window", m_window, exp_q[0].win);
               chk("m_row", m_row, exp_q[0].row);
               chk("m_col", m_col, exp_q[0].col);
               if (m_ready) begin
                  got_q.push_back({m_window, m_row, m_col});
                  void'(exp_q.pop_front());
                  win_cnt++;
               end
            end
         end
         if (m2_valid) begin
            if (exp2_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_s2_window: row=%0d col=%0d", m2_row, m2_col);
            end else begin
               chk("s2_window", m2_window, exp2_q[0].win);
               chk("s2_row", m2_row, exp2_q[0].row);
               chk("s2_col", m2_col, exp2_q[0].col);
               got2_q.push_back({m2_window, m2_row, m2_col});
               void'(exp2_q.pop_front());
               win2_cnt++;
            end
         end
      end
   end

   task automatic send_pixel(input int base, input int r, input int c);
      bit ok;
      int n;
      ok      = 1'b0;
      n       = 0;
      s_valid = 1'b1;
      s_data  = 8'(base + r*W + c + 1);
      while (!ok && n < 200) begin
         @(negedge clk); #1;
         ok = s_ready;
         @(posedge clk); #1;
         n++;
      end
      s_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted in %0d cycles", r, c, n);
      end else if (r >= N-1 && c >= N-1) begin
         exp_q.push_back({model_win(base, r, c), 3'(r-N+1), 3'(c-N+1)});
      end
   endtask

   task automatic send_frame(input int base, input int maxgap);
      int g;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (g) begin
               @(posedge clk); #1;
            end
            send_pixel(base, r, c);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic new_test();
      win_cnt = 0;
      fd_cnt  = 0;
      got_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      s2_valid = 1'b0; s2_data = '0; m2_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_window", m_window, 0);
      chk("rst_m_row", m_row, 0);
      chk("rst_m_col", m_col, 0);
      chk("rst_frame_done", frame_done, 0);

      // Single frame at full throughput
      new_test();
      send_frame(0, 0);
      drain();
      chk("t1_windows", win_cnt, 9);
      chk("t1_frame_done", fd_cnt, 1);
      if (got_q.size() == 9) begin
         chk("t1_first_win", got_q[0].win, win9(1, 2, 3, 6, 7, 8, 11, 12, 13));
         chk("t1_first_rc", {got_q[0].row, got_q[0].col}, {3'd0, 3'd0});
         chk("t1_last_win", got_q[8].win, win9(13, 14, 15, 18, 19, 20, 23, 24, 25));
         chk("t1_last_rc", {got_q[8].row, got_q[8].col}, {3'd2, 3'd2});
      end

      // Stride-2 instance
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            s2_valid = 1'b1;
            s2_data  = 8'(r*W + c + 1);
            chk("s2_ready", s2_ready, 1);
            if (r >= 2 && c >= 2 && (r-2) % 2 == 0 && (c-2) % 2 == 0) begin
               exp2_q.push_back({model_win(0, r, c), 3'(r-2), 3'(c-2)});
            end
            @(posedge clk); #1;
         end
      end
      s2_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("t2_windows", win2_cnt, 4);
      chk("t2_pending", exp2_q.size(), 0);
      if (got2_q.size() == 4) begin
         chk("t2_rc1", {got2_q[1].row, got2_q[1].col}, {3'd0, 3'd2});
         chk("t2_rc2", {got2_q[2].row, got2_q[2].col}, {3'd2, 3'd0});
         chk("t2_win_2_2", got2_q[3].win, win9(13, 14, 15, 18, 19, 20, 23, 24, 25));
      end

      // Backpressure from the first window for ten cycles
      new_test();
      #1 m_ready = 1'b0;
      fork
         send_frame(0, 0);
         begin
            int n;
            n = 0;
            while (!m_valid && n < 100) begin
               @(posedge clk); #1;
               n++;
            end
            repeat (10) begin
               chk("bp_s_ready", s_ready, 0);
               chk("bp_hold", m_window, win9(1, 2, 3, 6, 7, 8, 11, 12, 13));
               @(posedge clk); #1;
            end
            #1 m_ready = 1'b1;
         end
      join
      drain();
      chk("t3_windows", win_cnt, 9);
      chk("t3_frame_done", fd_cnt, 1);

      // Two frames back to back
      new_test();
      send_frame(0, 0);
      send_frame(100, 0);
      drain();
      chk("t4_windows", win_cnt, 18);
      chk("t4_frame_done", fd_cnt, 2);
      if (got_q.size() == 18) begin
         chk("t4_f2_first", got_q[9].win, win9(101, 102, 103, 106, 107, 108, 111, 112, 113));
         chk("t4_f2_rc", {got_q[9].row, got_q[9].col}, {3'd0, 3'd0});
      end

      // Reset mid-frame with a stalled window in flight, then a gappy restart
      new_test();
      for (int p = 0; p < 12; p++) send_pixel(0, p / W, p % W);
      #1 m_ready = 1'b0;
      send_pixel(0, 2, 2);
      chk("t5_latency", m_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_rst_m_valid", m_valid, 0);
      chk("t5_rst_s_ready", s_ready, 1);
      exp_q.delete();
      #1 m_ready = 1'b1;
      new_test();
      send_frame(50, 2);
      drain();
      chk("t5_windows", win_cnt, 9);
      chk("t5_frame_done", fd_cnt, 1);
      if (got_q.size() == 9) begin
         chk("t5_first_win", got_q[0].win, win9(51, 52, 53, 56, 57, 58, 61, 62, 63));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
